// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the dot framebuffer.
//   state_e  - clear sequencer states
//   Reg*     - Wishbone register addresses
//   DropMax  - saturation value of the dropped-dot counter
package fb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } state_e;

  localparam logic [7:0] RegCtrl = 8'h00;
  localparam logic [7:0] RegPen  = 8'h01;
  localparam logic [7:0] RegDrop = 8'h02;

  localparam logic [7:0] DropMax = 8'hFF;

endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port 1-bit RAM for the framebuffer.
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address (registered read)
//   rdata_o  - read data, one cycle after raddr_i; returns the old value
//              when the same address is written in the same cycle
module fb_ram #(
  parameter int Depth  = 5000,
  parameter int AddrSz = 13
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AddrSz-1:0] waddr_i,
  input  logic              wdata_i,
  input  logic [AddrSz-1:0] raddr_i,
  output logic              rdata_o
);

  logic mem [Depth];
  logic rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents are
  // defined only after a clear has swept every address.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/peri_framebuffer.sv
// peri_framebuffer: 1-bpp framebuffer fed by a dot stream.
//   clk_i / rst_ni        - clock, asynchronous active-low reset
//   wb_*                  - Wishbone B4 slave, zero wait state
//                           0x00 CTRL (bit0 read busy / write start clear)
//                           0x01 PEN  (bit0 pixel value drawn by dots)
//                           0x02 DROP (dropped-dot count, write clears)
//   dot_row_i/col_i/valid - incoming dots, no backpressure
//   scan_row_i/col_i/req  - display read port, 2-cycle latency
//   scan_pixel_o/valid_o  - read result
module peri_framebuffer
  import fb_pkg::*;
#(
  parameter int ScreenWidth  = 100,
  parameter int ScreenHeight = 50,
  parameter int CoordSz      = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  output logic               wb_ack_o,
  input  logic [7:0]         wb_adr_i,
  input  logic [7:0]         wb_dat_i,
  output logic [7:0]         wb_dat_o,
  input  logic [CoordSz-1:0] dot_row_i,
  input  logic [CoordSz-1:0] dot_col_i,
  input  logic               dot_valid_i,
  input  logic [CoordSz-1:0] scan_row_i,
  input  logic [CoordSz-1:0] scan_col_i,
  input  logic               scan_req_i,
  output logic               scan_pixel_o,
  output logic               scan_valid_o
);

  localparam int Depth  = ScreenWidth * ScreenHeight;
  localparam int AddrSz = $clog2(Depth);
  localparam int ProdSz = CoordSz + $clog2(ScreenWidth) + 2;

  // Linear address from the full-width coordinates, truncated afterwards.
  function automatic logic [AddrSz-1:0] pix_addr(input logic [CoordSz-1:0] row,
                                                 input logic [CoordSz-1:0] col);
    logic [ProdSz-1:0] full;
    full = ProdSz'(row) * ProdSz'(ScreenWidth) + ProdSz'(col);
    return full[AddrSz-1:0];
  endfunction

  function automatic logic in_range(input logic [CoordSz-1:0] row,
                                    input logic [CoordSz-1:0] col);
    return (row < CoordSz'(ScreenHeight)) && (col < CoordSz'(ScreenWidth));
  endfunction

  // ---------------- Wishbone decode ----------------
  logic wb_wr;
  logic unused_wb_dat;
  assign wb_ack_o      = wb_stb_i;
  assign wb_wr         = wb_stb_i & wb_we_i;
  assign unused_wb_dat = ^wb_dat_i[7:1];

  state_e            state_q, state_d;
  logic [AddrSz-1:0] clr_addr_q, clr_addr_d;
  logic              pen_q;
  logic [7:0]        drop_cnt_q;
  logic              busy;

  assign busy = (state_q == StClear);

  always_comb begin
    wb_dat_o = '0;
    if (wb_stb_i) begin
      unique case (wb_adr_i)
        RegCtrl: wb_dat_o = {7'd0, busy};
        RegPen:  wb_dat_o = {7'd0, pen_q};
        RegDrop: wb_dat_o = drop_cnt_q;
        default: wb_dat_o = '0;
      endcase
    end
  end

  // ---------------- Clear sequencer ----------------
  logic ctrl_start;
  assign ctrl_start = wb_wr && (wb_adr_i == RegCtrl) && wb_dat_i[0];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      StIdle: begin
        if (ctrl_start) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      StClear: begin
        // Start requests are ignored here so a clear is never stretched.
        if (clr_addr_q == AddrSz'(Depth - 1)) begin
          state_d = StIdle;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // ---------------- Dot path ----------------
  logic [AddrSz-1:0] dot_addr_q;
  logic              dot_rng_q;
  logic              dot_vld_q;
  logic              dot_write;
  logic              dot_drop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dot_addr_q <= '0;
      dot_rng_q  <= 1'b0;
      dot_vld_q  <= 1'b0;
    end else begin
      dot_addr_q <= pix_addr(dot_row_i, dot_col_i);
      dot_rng_q  <= in_range(dot_row_i, dot_col_i);
      dot_vld_q  <= dot_valid_i;
    end
  end

  // Every valid dot is either written or counted as dropped.
  assign dot_write = dot_vld_q & dot_rng_q & ~busy;
  assign dot_drop  = dot_vld_q & ~dot_write;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pen_q      <= 1'b1;
      drop_cnt_q <= '0;
    end else begin
      if (wb_wr && (wb_adr_i == RegPen)) begin
        pen_q <= wb_dat_i[0];
      end
      // A clearing write wins over a simultaneous increment.
      if (wb_wr && (wb_adr_i == RegDrop)) begin
        drop_cnt_q <= '0;
      end else if (dot_drop && (drop_cnt_q != DropMax)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // ---------------- Scan path ----------------
  logic [AddrSz-1:0] scan_addr_q;
  logic              scan_rng_q, scan_rng_q2;
  logic              scan_req_q;
  logic              scan_valid_q;
  logic              ram_rdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_addr_q  <= '0;
      scan_rng_q   <= 1'b0;
      scan_rng_q2  <= 1'b0;
      scan_req_q   <= 1'b0;
      scan_valid_q <= 1'b0;
    end else begin
      // Out-of-range reads are steered to address 0 and masked on output.
      scan_addr_q  <= in_range(scan_row_i, scan_col_i) ?
                      pix_addr(scan_row_i, scan_col_i) : '0;
      scan_rng_q   <= in_range(scan_row_i, scan_col_i);
      scan_req_q   <= scan_req_i;
      scan_rng_q2  <= scan_rng_q;
      scan_valid_q <= scan_req_q;
    end
  end

  assign scan_valid_o = scan_valid_q;
  assign scan_pixel_o = ram_rdata & scan_rng_q2;

  // ---------------- RAM ----------------
  fb_ram #(
    .Depth  (Depth),
    .AddrSz (AddrSz)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (busy | dot_write),
    .waddr_i (busy ? clr_addr_q : dot_addr_q),
    .wdata_i (busy ? 1'b0 : pen_q),
    .raddr_i (scan_addr_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: doc/peri_framebuffer.md
Name: peri_framebuffer

Overview:
Sink end of the dot interface driven by the line-drawing peripheral: accepts one (row, col) dot per cycle and stores it in a 1-bit-per-pixel framebuffer RAM. A second read port serves a display scanner. A Wishbone B4 register slice provides clear, pen colour and dropped-dot statistics. Sits between the draw peripherals and the video scan-out logic.

Parameters:
ScreenWidth, 100, pixels per row
ScreenHeight, 50, rows
CoordSz, 16, width of dot and scan coordinates; must match the dot producer

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
wb_we_i  in  1  wishbone write enable
wb_stb_i  in  1  wishbone strobe
wb_ack_o  out  1  wishbone ack, equals wb_stb_i (zero wait state)
wb_adr_i  in  8  register address
wb_dat_i  in  8  write data
wb_dat_o  out  8  read data
dot_row_i  in  CoordSz  dot row
dot_col_i  in  CoordSz  dot column
dot_valid_i  in  1  dot present this cycle; no backpressure, a dot is accepted or dropped the same cycle
scan_row_i  in  CoordSz  scan read row
scan_col_i  in  CoordSz  scan read column
scan_req_i  in  1  scan read request
scan_pixel_o  out  1  pixel value read
scan_valid_o  out  1  scan_pixel_o valid

Behaviour:
- One clock; reset asynchronous, active-low, on rst_ni. RAM contents are not reset.
- Reset values: wb_dat_o=0, scan_pixel_o=0, scan_valid_o=0, pen=1, drop_cnt=0, state=StClear, clear address=0.
- Pixel address = row*ScreenWidth + col, AddrSz = clog2(ScreenWidth*ScreenHeight); computed on full CoordSz inputs before truncation.
- Dot path, 2 stages. S1 registers address, in-range flag (row<ScreenHeight and col<ScreenWidth), valid. S2 writes pen to RAM if valid, in range, and state==StIdle. A dot written in cycle N is visible to a scan read issued in cycle N+2.
- Dropped dots: valid but out of range, or arriving during StClear. drop_cnt increments by 1 per dropped dot, saturates at 255.
- FSM StClear: writes 0 to clear address, increments by 1 per cycle. At ScreenWidth*ScreenHeight-1, the final write occurs and the FSM goes to StIdle. Duration is exactly ScreenWidth*ScreenHeight cycles.
- FSM StIdle: a Wishbone write to CTRL with bit0=1 enters StClear with address 0 on the next cycle. A CTRL write during StClear is ignored; the clear does not restart.
- Reset asserted mid-clear: the FSM returns to StClear at address 0, so the clear restarts from scratch after reset release.
- Scan path: latency 2 cycles (address register, then registered RAM read). scan_valid_o follows scan_req_i delayed by 2. An out-of-range scan request returns pixel 0 with valid still asserted.
- Scan read is always serviced, including during clear. A scan read and a dot write to the same address in the same RAM cycle returns the old value (read-first).
- Registers (read data combinational from the address, registered into wb_dat_o? no: wb_dat_o is combinational, valid while wb_stb_i is high):
  - 0x00 CTRL: read bit0=busy (state==StClear); write bit0=1 starts a clear.
  - 0x01 PEN: bit0, the pixel value written by dots (1 draws, 0 erases). Reads back.
  - 0x02 DROP: read drop_cnt; any write clears it to 0. A write and an increment in the same cycle yields 0.
  - Other addresses: read 0, writes ignored.

Decomposition:
- Package fb_pkg: state enum {StIdle, StClear}; register address constants RegCtrl=8'h00, RegPen=8'h01, RegDrop=8'h02.
- Sub-module fb_ram: simple dual-port 1-bit RAM, depth ScreenWidth*ScreenHeight, one synchronous write port, one synchronous read-first read port, no reset. Must infer block RAM.

Test Plan:
- Reset, then hold dot_valid_i=0 -> CTRL reads 1 for 5000 cycles, then 0; a scan of (49,99) returns 0 with scan_valid_o exactly 2 cycles after the request.
- After clear, dot (3,7) with pen=1 -> 2 cycles later a scan of (3,7) returns 1 and a scan of (3,8) returns 0.
- Dots (50,0), (0,100), (65535,65535) -> DROP reads 3, no RAM write; write DROP -> reads 0.
- Write CTRL=1, then send 10 dots during the clear -> DROP=10, all pixels 0 after busy falls. A second CTRL write mid-clear does not extend busy beyond 5000 cycles.
- PEN=0, dot (3,7) on a set pixel -> scan returns 0. Same-cycle scan read and dot write to (5,5) -> old value returned, new value on the next read.
- Assert rst_ni asynchronously mid-clear at address 2000 -> all outputs at reset values immediately, and busy lasts a full 5000 cycles after release.
